// File: rtl/rs_pkg.sv
// Shared defaults and CDB packing helpers for the reservation station.
// Latency: none (constants and a pure function only).
// Backpressure: none.
package rs_pkg;

  localparam int RS_DEPTH  = 8;
  localparam int RS_ROB_W  = 4;
  localparam int RS_NCDB   = 2;
  localparam int RS_OP_W   = 7;
  localparam int CDB_VAL_W = 32;

  // Bit offset of channel k inside a packed CDB bus whose per-channel field is w bits.
  function automatic int cdb_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-eligible picker driven by an age matrix (age[i][j]=1: i issued before j).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rs_age_picker #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            eligible,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic                        valid,
  output logic [IDX_W-1:0]            idx
);

  logic [DEPTH-1:0] win;

  // An eligible entry wins when it is older than every other eligible entry.
  always_comb begin
    win = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win[i] = eligible[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && eligible[j] && !age[i][j]) win[i] = 1'b0;
      end
    end
  end

  // Encode the (at most one-hot) winner; valid whenever anything is eligible.
  always_comb begin
    valid = |eligible;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (win[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rs_gen.sv
// Reservation station: holds issued ops, wakes operands from the CDB, dispatches oldest ready.
// Latency: issue->visible next cycle; CDB wakeup->eligible next cycle; dispatch offer is combinational.
// Backpressure: issue_ready drops when full; exe_* held stable while exe_valid && !exe_ready.
module rs_gen
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int ROB_W = RS_ROB_W,
  parameter int NCDB  = RS_NCDB,
  parameter int OP_W  = RS_OP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [OP_W-1:0]            issue_op,
  input  logic [31:0]                issue_pc,
  input  logic [31:0]                issue_v1,
  input  logic [31:0]                issue_v2,
  input  logic                       issue_dep1,
  input  logic                       issue_dep2,
  input  logic [ROB_W-1:0]           issue_q1,
  input  logic [ROB_W-1:0]           issue_q2,
  input  logic [ROB_W-1:0]           issue_rob,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*ROB_W-1:0]      cdb_rob,
  input  logic [NCDB*CDB_VAL_W-1:0]  cdb_value,
  output logic                       exe_valid,
  input  logic                       exe_ready,
  output logic [OP_W-1:0]            exe_op,
  output logic [31:0]                exe_pc,
  output logic [31:0]                exe_v1,
  output logic [31:0]                exe_v2,
  output logic [ROB_W-1:0]           exe_rob,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]            busy, dep1, dep2;
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [OP_W-1:0]             op_q  [DEPTH];
  logic [31:0]                 pc_q  [DEPTH];
  logic [31:0]                 v1_q  [DEPTH];
  logic [31:0]                 v2_q  [DEPTH];
  logic [ROB_W-1:0]            q1_q  [DEPTH];
  logic [ROB_W-1:0]            q2_q  [DEPTH];
  logic [ROB_W-1:0]            rob_q [DEPTH];

  logic [DEPTH-1:0] wk1, wk2;
  logic [31:0]      wv1 [DEPTH];
  logic [31:0]      wv2 [DEPTH];
  logic             iwk1, iwk2;
  logic [31:0]      iwv1, iwv2;
  logic [IDX_W-1:0] free_idx, pick_idx;
  logic [CNT_W-1:0] cnt;
  logic             pick_valid, issue_fire, disp_fire;
  logic [DEPTH-1:0] eligible;

  // CDB tag match for stored and incoming operands; scanning high-to-low lets channel 0 win ties.
  always_comb begin
    logic [ROB_W-1:0] ctag;
    logic [31:0]      cval;
    ctag = '0;
    cval = '0;
    wk1  = '0;
    wk2  = '0;
    iwk1 = 1'b0;
    iwk2 = 1'b0;
    iwv1 = '0;
    iwv2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wv1[i] = '0;
      wv2[i] = '0;
    end
    for (int k = NCDB - 1; k >= 0; k--) begin
      ctag = cdb_rob[cdb_lsb(k, ROB_W) +: ROB_W];
      cval = cdb_value[cdb_lsb(k, CDB_VAL_W) +: CDB_VAL_W];
      if (cdb_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ctag == q1_q[i]) begin wk1[i] = 1'b1; wv1[i] = cval; end
          if (ctag == q2_q[i]) begin wk2[i] = 1'b1; wv2[i] = cval; end
        end
        if (ctag == issue_q1) begin iwk1 = 1'b1; iwv1 = cval; end
        if (ctag == issue_q2) begin iwk2 = 1'b1; iwv2 = cval; end
      end
    end
  end

  // Lowest free slot for the next issue, and occupancy straight from the busy bits.
  always_comb begin
    free_idx = '0;
    cnt      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      cnt = cnt + CNT_W'(busy[i]);
    end
  end

  assign eligible = busy & ~dep1 & ~dep2;

  rs_age_picker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_picker (
    .eligible (eligible),
    .age      (age),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign count       = cnt;
  assign issue_ready = (cnt < CNT_W'(DEPTH));
  assign exe_valid   = pick_valid && rdy;
  assign issue_fire  = issue_valid && issue_ready && rdy && !flush;
  assign disp_fire   = exe_valid && exe_ready && !flush;
  assign exe_op      = pick_valid ? op_q[pick_idx]  : '0;
  assign exe_pc      = pick_valid ? pc_q[pick_idx]  : '0;
  assign exe_v1      = pick_valid ? v1_q[pick_idx]  : '0;
  assign exe_v2      = pick_valid ? v2_q[pick_idx]  : '0;
  assign exe_rob     = pick_valid ? rob_q[pick_idx] : '0;

  // Control state: occupancy, operand readiness and issue-order age matrix.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      dep1 <= '0;
      dep2 <= '0;
      age  <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && wk1[i]) dep1[i] <= 1'b0;
          if (busy[i] && wk2[i]) dep2[i] <= 1'b0;
        end
        if (disp_fire) busy[pick_idx] <= 1'b0;
        if (issue_fire) begin
          busy[free_idx] <= 1'b1;
          dep1[free_idx] <= issue_dep1 && !iwk1;
          dep2[free_idx] <= issue_dep2 && !iwk2;
          // New entry is younger than everything currently held.
          for (int j = 0; j < DEPTH; j++) begin
            age[free_idx][j] <= 1'b0;
            age[j][free_idx] <= (j != int'(free_idx));
          end
        end
      end
    end
  end

  // Payload storage; contents are only meaningful while the slot is busy.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_fire && int'(free_idx) == i) begin
          op_q[i]  <= issue_op;
          pc_q[i]  <= issue_pc;
          v1_q[i]  <= (issue_dep1 && iwk1) ? iwv1 : issue_v1;
          v2_q[i]  <= (issue_dep2 && iwk2) ? iwv2 : issue_v2;
          q1_q[i]  <= issue_q1;
          q2_q[i]  <= issue_q2;
          rob_q[i] <= issue_rob;
        end else begin
          if (busy[i] && dep1[i] && wk1[i]) v1_q[i] <= wv1[i];
          if (busy[i] && dep2[i] && wk2[i]) v2_q[i] <= wv2[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_gen.sv
// Bench for rs_gen: directed scenarios then random traffic against a queue-based model.
// Latency: model advances once per rising edge, outputs compared on the falling edge.
// Backpressure: exe_ready and rdy are driven by the bench, randomly in the soak phase.
module tb_rs_gen;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        issue_valid, issue_ready;
  logic [6:0]  issue_op;
  logic [31:0] issue_pc, issue_v1, issue_v2;
  logic        issue_dep1, issue_dep2;
  logic [3:0]  issue_q1, issue_q2, issue_rob;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob;
  logic [63:0] cdb_value;
  logic        exe_valid, exe_ready;
  logic [6:0]  exe_op;
  logic [31:0] exe_pc, exe_v1, exe_v2;
  logic [3:0]  exe_rob;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] pc, v1, v2;
    logic        d1, d2;
    logic [3:0]  q1, q2, rob;
  } ent_t;

  // Entries in issue order: index 0 is the oldest.
  ent_t mq[$];

  rs_gen dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_pc(issue_pc),
    .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_dep1(issue_dep1), .issue_dep2(issue_dep2),
    .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_rob(issue_rob),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .exe_valid(exe_valid), .exe_ready(exe_ready),
    .exe_op(exe_op), .exe_pc(exe_pc), .exe_v1(exe_v1), .exe_v2(exe_v2),
    .exe_rob(exe_rob), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = '0;
    flush       = 1'b0;
  endtask

  task automatic iss(input logic [3:0] rob, input logic d1, input logic [3:0] q1,
                     input logic d2, input logic [3:0] q2);
    issue_valid = 1'b1;
    issue_op    = 7'($urandom);
    issue_pc    = $urandom;
    issue_v1    = $urandom;
    issue_v2    = $urandom;
    issue_rob   = rob;
    issue_dep1  = d1;
    issue_q1    = q1;
    issue_dep2  = d2;
    issue_q2    = q2;
  endtask

  task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[ch]         = 1'b1;
    cdb_rob[ch*4 +: 4]    = tag;
    cdb_value[ch*32 +: 32] = val;
  endtask

  // Operand capture: lowest valid channel with a matching tag supplies the value.
  function automatic void wake(inout ent_t e);
    bit h1 = 0;
    bit h2 = 0;
    for (int k = 0; k < 2; k++) begin
      if (cdb_valid[k]) begin
        if (e.d1 && !h1 && cdb_rob[k*4 +: 4] == e.q1) begin e.v1 = cdb_value[k*32 +: 32]; h1 = 1; end
        if (e.d2 && !h2 && cdb_rob[k*4 +: 4] == e.q2) begin e.v2 = cdb_value[k*32 +: 32]; h2 = 1; end
      end
    end
    if (h1) e.d1 = 1'b0;
    if (h2) e.d2 = 1'b0;
  endfunction

  // Compare outputs mid-cycle, then advance the model across one rising edge.
  task automatic tick();
    int   sel;
    bit   ev, acc;
    ent_t e;
    @(negedge clk);
    sel = -1;
    foreach (mq[i]) if (sel < 0 && !mq[i].d1 && !mq[i].d2) sel = i;
    ev = rdy && (sel >= 0);
    chk("exe_valid", exe_valid, ev);
    chk("issue_ready", issue_ready, mq.size() < 8);
    chk("count", count, mq.size());
    if (ev) begin
      chk("exe_op",  exe_op,  mq[sel].op);
      chk("exe_pc",  exe_pc,  mq[sel].pc);
      chk("exe_v1",  exe_v1,  mq[sel].v1);
      chk("exe_v2",  exe_v2,  mq[sel].v2);
      chk("exe_rob", exe_rob, mq[sel].rob);
    end
    @(posedge clk);
    if (rdy) begin
      if (flush) begin
        mq.delete();
      end else begin
        acc = issue_valid && (mq.size() < 8);
        if (ev && exe_ready) mq.delete(sel);
        foreach (mq[i]) wake(mq[i]);
        if (acc) begin
          e.op = issue_op; e.pc = issue_pc; e.v1 = issue_v1; e.v2 = issue_v2;
          e.d1 = issue_dep1; e.d2 = issue_dep2;
          e.q1 = issue_q1; e.q2 = issue_q2; e.rob = issue_rob;
          wake(e);
          mq.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [3:0] held;
    rst = 1'b0; rdy = 1'b1; exe_ready = 1'b0;
    issue_op = '0; issue_pc = '0; issue_v1 = '0; issue_v2 = '0;
    issue_dep1 = 1'b0; issue_dep2 = 1'b0; issue_q1 = '0; issue_q2 = '0; issue_rob = '0;
    cdb_rob = '0; cdb_value = '0;
    idle();

    // Reset values.
    #12;
    chk("rst_exe_valid", exe_valid, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_exe_op", exe_op, 0);
    chk("rst_exe_pc", exe_pc, 0);
    chk("rst_exe_v1", exe_v1, 0);
    chk("rst_exe_v2", exe_v2, 0);
    chk("rst_exe_rob", exe_rob, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill all eight slots with ready ops; the ninth offer must be refused.
    for (int n = 0; n < 9; n++) begin
      iss(4'(n), 0, 0, 0, 0);
      tick();
    end
    idle();
    chk("full_count", count, 8);
    chk("full_issue_ready", issue_ready, 0);

    // Flush while full, with an issue and a dispatch offered the same edge.
    iss(4'd9, 0, 0, 0, 0);
    exe_ready = 1'b1;
    flush = 1'b1;
    tick();
    idle();
    exe_ready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_exe_valid", exe_valid, 0);
    chk("flush_issue_ready", issue_ready, 1);

    // Wakeup from channel 1 makes the entry eligible the cycle after the broadcast.
    iss(4'd3, 1, 4'd5, 0, 0);
    tick();
    idle();
    cdb(1, 4'd5, 32'hDEADBEEF);
    tick();
    idle();
    chk("wake_exe_valid", exe_valid, 1);
    chk("wake_exe_v1", exe_v1, 32'hDEADBEEF);
    chk("wake_exe_rob", exe_rob, 3);
    exe_ready = 1'b1;
    tick();
    exe_ready = 1'b0;

    // Issue-time bypass, both channels carrying the tag: channel 0 value wins.
    iss(4'd6, 1, 4'd2, 0, 0);
    cdb(0, 4'd2, 32'h11);
    cdb(1, 4'd2, 32'h22);
    tick();
    idle();
    chk("bypass_exe_valid", exe_valid, 1);
    chk("bypass_exe_v1", exe_v1, 32'h11);
    exe_ready = 1'b1;
    tick();
    exe_ready = 1'b0;

    // Age order: X(8) slot0, A(1, waiting) slot1, B(2) slot2.
    iss(4'd8, 0, 0, 0, 0); tick();
    iss(4'd1, 1, 4'd7, 0, 0); tick();
    iss(4'd2, 0, 0, 0, 0); tick();
    idle();
    exe_ready = 1'b1;
    tick();
    chk("age_b_first", exe_rob, 2);
    tick();
    exe_ready = 1'b0;
    // Wake A and put C into the lower free slot; A must still go first.
    cdb(0, 4'd7, 32'hA5A5_0001);
    iss(4'd9, 0, 0, 0, 0);
    tick();
    idle();
    chk("age_a_before_c", exe_rob, 1);
    tick();

    // rdy low: everything frozen for three cycles despite active inputs.
    held = count;
    rdy = 1'b0;
    iss(4'd4, 0, 0, 0, 0);
    exe_ready = 1'b1;
    cdb(0, 4'd7, 32'h1234);
    for (int n = 0; n < 3; n++) tick();
    chk("freeze_count", count, held);
    chk("freeze_exe_valid", exe_valid, 0);
    rdy = 1'b1;
    idle();
    exe_ready = 1'b0;
    tick();

    // Asynchronous reset mid-cycle with an issue and a dispatch pending.
    iss(4'd5, 0, 0, 0, 0);
    exe_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_exe_valid", exe_valid, 0);
    chk("arst_issue_ready", issue_ready, 1);
    chk("arst_count", count, 0);
    chk("arst_exe_rob", exe_rob, 0);
    chk("arst_exe_pc", exe_pc, 0);
    mq.delete();
    @(posedge clk); #1;
    idle();
    exe_ready = 1'b0;
    rst = 1'b1;
    tick();

    // Random soak against the model.
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 59) == 0);
      exe_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) != 0)
        iss(4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 1) != 0) cdb(k, 4'($urandom), $urandom);
      tick();
    end
    idle();
    rdy = 1'b1;
    exe_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_gen.md
RS_GEN -- requirements
Module: rs_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, >=2).
REQ-002 SHALL have parameter ROB_W, default 4, RoB tag width.
REQ-003 SHALL have parameter NCDB, default 2, number of result broadcast channels.
REQ-004 SHALL have parameter OP_W, default 7, opcode/type field width.
REQ-005 SHALL have ports (clock and reset first):
 - clk  input  1  single clock, rising edge.
 - rst  input  1  reset, asynchronous, active-low (already decided).
 - rdy  input  1  global enable; low freezes all state.
 - flush  input  1  RoB mispredict clear.
 - issue_valid  input  1  new instruction offered.
 - issue_ready  output  1  free entry exists.
 - issue_op  input  OP_W  operation type.
 - issue_pc  input  32  instruction address.
 - issue_v1, issue_v2  input  32 each  operand values.
 - issue_dep1, issue_dep2  input  1 each  operand still pending.
 - issue_q1, issue_q2  input  ROB_W each  producer tags.
 - issue_rob  input  ROB_W  destination tag.
 - cdb_valid  input  NCDB  per-channel broadcast valid.
 - cdb_rob  input  NCDB*ROB_W  packed tags, channel 0 in LSBs.
 - cdb_value  input  NCDB*32  packed values, channel 0 in LSBs.
 - exe_valid  output  1  entry offered to ALU.
 - exe_ready  input  1  ALU accepts.
 - exe_op, exe_pc, exe_v1, exe_v2, exe_rob  output  OP_W/32/32/32/ROB_W  selected entry fields.
 - count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-006 SHALL accept an issue on an edge where issue_valid && issue_ready && rdy && !flush, writing the lowest-index free entry.
REQ-007 SHALL drive issue_ready = (count < DEPTH), computed from registered state only.
REQ-008 SHALL, on each edge, for every busy entry and each operand with dep set, clear dep and capture the value when any cdb_valid[k] has a matching cdb_rob[k].
REQ-009 SHALL apply REQ-008 also to the instruction being issued that edge (issue-time bypass), so an operand broadcast in the issue cycle is never lost.
REQ-010 SHALL resolve multiple channels matching one tag by taking the lowest channel index.
REQ-011 SHALL treat an entry as eligible when busy && !dep1 && !dep2 in registered state; eligibility after wakeup appears one cycle after the broadcast edge.
REQ-012 SHALL select the oldest eligible entry (issue order, tracked by a DEPTH x DEPTH age matrix), not lowest index.
REQ-013 SHALL drive exe_valid = any eligible && rdy, with exe_* fields from the selected entry, combinationally.
REQ-014 SHALL hold exe_* stable while exe_valid && !exe_ready (no reselection unless an older entry becomes eligible).
REQ-015 SHALL free the selected entry on an edge with exe_valid && exe_ready; freed slot is reusable from the next cycle.
REQ-016 SHALL allow issue and dispatch on the same edge; count then unchanged.
REQ-017 SHALL, on flush with rdy high, clear all busy bits at that edge; flush overrides issue, wakeup and dispatch.
REQ-018 SHALL keep count equal to number of busy entries at all times; never exceed DEPTH.
REQ-019 SHALL, while rdy is low, hold all state and drive exe_valid 0.

Reset
REQ-020 SHALL, while rst is low, asynchronously clear all busy and dep bits and the age matrix.
REQ-021 SHALL output after reset: exe_valid 0, issue_ready 1, count 0, exe_* fields 0.
REQ-022 SHALL discard any in-flight issue or dispatch when reset asserts mid-operation.

Structure
REQ-023 SHALL place default DEPTH, ROB_W, NCDB, OP_W and the CDB packing helper constants in shared package rs_pkg.
REQ-024 SHALL implement oldest-eligible selection in sub-module rs_age_picker (inputs eligible vector and age matrix, outputs valid and index).

Verification
REQ-025 Issue 8 entries no deps, exe_ready low -> issue_ready 0 after 8th, count 8; 9th issue_valid ignored.
REQ-026 Issue tag 3 dep1 on q1=5, then cdb ch1 rob=5 value 0xDEADBEEF -> exe_valid next cycle, exe_v1 0xDEADBEEF, exe_rob 3.
REQ-027 Issue dep on q1=2 in same cycle as cdb ch0 rob=2 value 0x11 -> entry eligible next cycle, exe_v1 0x11.
REQ-028 Issue A(rob1, dep), B(rob2, ready), then wake A -> B dispatched first; with both ready, A (older) dispatched before C issued later into lower index.
REQ-029 Full RS, flush with simultaneous issue and dispatch -> next cycle count 0, exe_valid 0, issue_ready 1.
REQ-030 Drop rst mid-stream asynchronously -> outputs per REQ-021 before next clk edge; rdy low for 3 cycles -> state and count unchanged.
